// File: rtl/multicycle_alu_if.sv
// Handshake and data bundle between the execute-stage pipeline (master) and
// the multicycle ALU (slave).
//   flush      master->slave  abort the in-flight or held operation
//   in_valid   master->slave  operation request
//   in_ready   slave->master  unit can accept this cycle
//   operation  master->slave  bit4=0: base op in [3:0]; bit4=1: M op in [2:0]
//   in_x/in_y  master->slave  operands
//   out_valid  slave->master  result held on out_s/out_zr
//   out_ready  master->slave  consumer takes result
//   out_s      slave->master  registered result
//   out_zr     slave->master  registered zero flag
//   busy       slave->master  multiply/divide iterating
interface multicycle_alu_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      operation;
    logic [XLEN-1:0] in_x;
    logic [XLEN-1:0] in_y;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_s;
    logic            out_zr;
    logic            busy;

    modport master (
        output flush, in_valid, operation, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_s, out_zr, busy
    );

    modport slave (
        input  flush, in_valid, operation, in_x, in_y, out_ready,
        output in_ready, out_valid, out_s, out_zr, busy
    );
endinterface

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle base integer ops plus iterative RV32M-style
// multiply/divide (one bit per cycle) behind a valid/ready handshake.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  multicycle_alu_if.slave (request, result and flush handshake)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a request, in_ready=1
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle
// DONE   | result held on out_s/out_zr, out_valid=1
module multicycle_alu #(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             rst,
    multicycle_alu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [SHW:0]    CNT_LOAD = (SHW+1)'(XLEN);
    localparam logic [SHW:0]    CNT_ONE  = (SHW+1)'(1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [SHW:0]      cnt;
    logic [2*XLEN-1:0] acc;      // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
    logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
    logic              neg_res;
    logic              sel_hi;   // MUL: take high half; DIV: take remainder
    logic [XLEN-1:0]   res_s;
    logic              res_zr;

    logic accept;
    assign bus.in_ready  = (state == S_IDLE) || (state == S_DONE && bus.out_ready);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state == S_MUL) || (state == S_DIV);
    assign bus.out_s     = res_s;
    assign bus.out_zr    = res_zr;
    assign accept        = bus.in_valid && bus.in_ready && !bus.flush;

    // ---------------- base operations ----------------
    logic [XLEN-1:0] base_res;
    logic            base_zr;
    logic [SHW-1:0]  shamt;
    assign shamt = bus.in_y[SHW-1:0];

    always_comb begin
        base_res = bus.in_x;
        case (bus.operation[3:0])
            4'b0000: base_res = bus.in_x & bus.in_y;
            4'b0001: base_res = bus.in_x | bus.in_y;
            4'b0010: base_res = bus.in_x + bus.in_y;
            4'b0011: base_res = {{(XLEN-1){1'b0}}, bus.in_x == bus.in_y};
            4'b0100: base_res = bus.in_x << shamt;
            4'b0101: base_res = bus.in_x >> shamt;
            4'b0111: base_res = $signed(bus.in_x) >>> shamt;
            4'b1000: base_res = bus.in_x ^ bus.in_y;
            4'b1001: base_res = ~(bus.in_x | bus.in_y);
            4'b1010: base_res = bus.in_x - bus.in_y;
            4'b1100: base_res = {{(XLEN-1){1'b0}}, $signed(bus.in_x) >= $signed(bus.in_y)};
            4'b1101: base_res = {{(XLEN-1){1'b0}}, bus.in_x >= bus.in_y};
            4'b1110: base_res = {{(XLEN-1){1'b0}}, $signed(bus.in_x) < $signed(bus.in_y)};
            4'b1111: base_res = {{(XLEN-1){1'b0}}, bus.in_x < bus.in_y};
            default: base_res = bus.in_x;
        endcase
    end

    // The 01xx group (shifts and the 0110 pass-through) never flags zero.
    assign base_zr = (bus.operation[3:2] != 2'b01) && (base_res == '0);

    // ---------------- M-op decode at acceptance ----------------
    logic [2:0]      m_op;
    logic            is_m, is_div;
    logic            sign_x, sign_y, x_neg, y_neg, m_neg, m_sel;
    logic [XLEN-1:0] mag_x, mag_y;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    assign m_op   = bus.operation[2:0];
    assign is_m   = bus.operation[4];
    assign is_div = m_op[2];
    // MUL low half is sign-agnostic, so treating it as signed x signed is harmless.
    assign sign_x = is_div ? !m_op[0] : (m_op[1:0] != 2'b11);
    assign sign_y = is_div ? !m_op[0] : !m_op[1];
    assign x_neg  = sign_x && bus.in_x[XLEN-1];
    assign y_neg  = sign_y && bus.in_y[XLEN-1];
    assign mag_x  = x_neg ? ('0 - bus.in_x) : bus.in_x;
    assign mag_y  = y_neg ? ('0 - bus.in_y) : bus.in_y;
    // Remainder follows the dividend sign; quotient/product follow sign mismatch.
    assign m_neg  = (is_div && m_op[1]) ? x_neg : (x_neg ^ y_neg);
    assign m_sel  = is_div ? m_op[1] : (m_op[1:0] != 2'b00);

    assign div_zero = (bus.in_y == '0);
    assign div_ovf  = !m_op[0] && (bus.in_x == MOST_NEG) && (&bus.in_y);
    assign fast     = is_div && (div_zero || div_ovf);
    assign fast_res = div_zero ? (m_op[1] ? bus.in_x : '1)
                               : (m_op[1] ? '0 : bus.in_x);

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, mul_fix;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_trial, div_pick, div_fix;
    logic [2*XLEN-1:0] div_next, iter_next;
    logic [XLEN-1:0]   final_res;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
    assign mul_fix  = neg_res ? ('0 - mul_next) : mul_next;

    // Partial remainder is always below the divisor, so the difference fits XLEN bits.
    assign div_shift = acc[2*XLEN-1:XLEN-1];
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_trial = div_shift[XLEN-1:0] - opnd;
    assign div_next  = {(div_ge ? div_trial : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    assign div_pick  = sel_hi ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    assign div_fix   = neg_res ? ('0 - div_pick) : div_pick;

    assign iter_next = (state == S_MUL) ? mul_next : div_next;
    assign final_res = (state == S_MUL)
                     ? (sel_hi ? mul_fix[2*XLEN-1:XLEN] : mul_fix[XLEN-1:0])
                     : div_fix;

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
            sel_hi  <= 1'b0;
            res_s   <= '0;
            res_zr  <= 1'b0;
        end else if (bus.flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (!is_m) begin
                            res_s  <= base_res;
                            res_zr <= base_zr;
                            state  <= S_DONE;
                        end else if (fast) begin
                            res_s  <= fast_res;
                            res_zr <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            acc     <= {{XLEN{1'b0}}, (is_div ? mag_x : mag_y)};
                            opnd    <= is_div ? mag_y : mag_x;
                            neg_res <= m_neg;
                            sel_hi  <= m_sel;
                            cnt     <= CNT_LOAD;
                            state   <= is_div ? S_DIV : S_MUL;
                        end
                    end else if (state == S_DONE && bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= iter_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        res_s  <= final_res;
                        res_zr <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;
    localparam int XLEN = 32;

    localparam logic [4:0] OP_AND    = 5'b00000;
    localparam logic [4:0] OP_OR     = 5'b00001;
    localparam logic [4:0] OP_SUM    = 5'b00010;
    localparam logic [4:0] OP_EQ     = 5'b00011;
    localparam logic [4:0] OP_SLL    = 5'b00100;
    localparam logic [4:0] OP_SRL    = 5'b00101;
    localparam logic [4:0] OP_PASS6  = 5'b00110;
    localparam logic [4:0] OP_SRA    = 5'b00111;
    localparam logic [4:0] OP_XOR    = 5'b01000;
    localparam logic [4:0] OP_NOR    = 5'b01001;
    localparam logic [4:0] OP_SUB    = 5'b01010;
    localparam logic [4:0] OP_PASSB  = 5'b01011;
    localparam logic [4:0] OP_GE     = 5'b01100;
    localparam logic [4:0] OP_GEU    = 5'b01101;
    localparam logic [4:0] OP_SLT    = 5'b01110;
    localparam logic [4:0] OP_SLTU   = 5'b01111;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] s;
        logic        zr;
        logic [7:0]  lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    multicycle_alu_if #(.XLEN(XLEN)) bus();
    multicycle_alu #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        bus.in_valid  = 1'b1;
        bus.operation = op;
        bus.in_x      = x;
        bus.in_y      = y;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        drive(op, x, y);
        step();
        bus.in_valid = 1'b0;
        bus.in_x     = 32'hDEAD_BEEF;
        bus.in_y     = 32'h1234_5678;
    endtask

    // Latency counted in cycles: 1 means out_valid right after the accepting edge.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_s !== 32'h0) begin n_err++; $display("FAIL reset_out_s got %h want 0", bus.out_s); end
        n_cmp++; if (bus.out_zr !== 1'b0) begin n_err++; $display("FAIL reset_out_zr got %0b want 0", bus.out_zr); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        rst = 1'b0;
        step();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_base();
        vec_t tv[18];
        tv[0]  = '{OP_SUB,   32'd5,         32'd5,         32'h0000_0000, 1'b1, 8'd1};
        tv[1]  = '{OP_SLL,   32'd0,         32'd3,         32'h0000_0000, 1'b0, 8'd1};
        tv[2]  = '{OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b0, 8'd1};
        tv[3]  = '{OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1, 8'd1};
        tv[4]  = '{OP_SRA,   32'h8000_0000, 32'd36,        32'hF800_0000, 1'b0, 8'd1};
        tv[5]  = '{OP_SUM,   32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1, 8'd1};
        tv[6]  = '{OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 8'd1};
        tv[7]  = '{OP_OR,    32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 8'd1};
        tv[8]  = '{OP_XOR,   32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 8'd1};
        tv[9]  = '{OP_NOR,   32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 8'd1};
        tv[10] = '{OP_EQ,    32'd1234,      32'd1234,      32'h0000_0001, 1'b0, 8'd1};
        tv[11] = '{OP_GE,    32'h8000_0000, 32'd1,         32'h0000_0000, 1'b1, 8'd1};
        tv[12] = '{OP_GEU,   32'h8000_0000, 32'd1,         32'h0000_0001, 1'b0, 8'd1};
        tv[13] = '{OP_SRL,   32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 8'd1};
        tv[14] = '{OP_PASS6, 32'h0,         32'd5,         32'h0000_0000, 1'b0, 8'd1};
        tv[15] = '{OP_SUB,   32'h0,         32'd1,         32'hFFFF_FFFF, 1'b0, 8'd1};
        tv[16] = '{OP_PASSB, 32'h0,         32'd7,         32'h0000_0000, 1'b1, 8'd1};
        tv[17] = '{OP_EQ,    32'd1,         32'd2,         32'h0000_0000, 1'b1, 8'd1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            issue(tv[i].op, tv[i].x, tv[i].y);
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL base%0d_valid got %0b want 1", i, bus.out_valid); end
            n_cmp++; if (bus.out_s !== tv[i].s) begin n_err++; $display("FAIL base%0d_s got %h want %h", i, bus.out_s, tv[i].s); end
            n_cmp++; if (bus.out_zr !== tv[i].zr) begin n_err++; $display("FAIL base%0d_zr got %0b want %0b", i, bus.out_zr, tv[i].zr); end
        end
        step();
    endtask

    task automatic run_m_table(input string tag, input vec_t v);
        int lat;
        issue(v.op, v.x, v.y);
        if (v.lat != 8'd1) begin
            n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL %s_busy got %0b want 1", tag, bus.busy); end
        end
        wait_valid(lat);
        n_cmp++; if (lat != int'(v.lat)) begin n_err++; $display("FAIL %s_latency got %0d want %0d", tag, lat, v.lat); end
        n_cmp++; if (bus.out_s !== v.s) begin n_err++; $display("FAIL %s_s got %h want %h", tag, bus.out_s, v.s); end
        n_cmp++; if (bus.out_zr !== 1'b0) begin n_err++; $display("FAIL %s_zr got %0b want 0", tag, bus.out_zr); end
        step();
    endtask

    task automatic test_mul();
        vec_t tv[8];
        tv[0] = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 8'd33};
        tv[1] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 8'd33};
        tv[2] = '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 8'd33};
        tv[3] = '{OP_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b0, 8'd33};
        tv[4] = '{OP_MULHSU, 32'd2,         32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 8'd33};
        tv[5] = '{OP_MULH,   32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 8'd33};
        tv[6] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 8'd33};
        tv[7] = '{OP_MUL,    32'd0,         32'd12345,     32'h0000_0000, 1'b0, 8'd33};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) run_m_table($sformatf("mul%0d", i), tv[i]);
    endtask

    task automatic test_div();
        vec_t tv[12];
        tv[0]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 8'd33};
        tv[1]  = '{OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 8'd33};
        tv[2]  = '{OP_DIVU, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0, 8'd1};
        tv[3]  = '{OP_REMU, 32'd7,         32'd0,         32'h0000_0007, 1'b0, 8'd1};
        tv[4]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 8'd1};
        tv[5]  = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 8'd1};
        tv[6]  = '{OP_DIVU, 32'd100,       32'd7,         32'h0000_000E, 1'b0, 8'd33};
        tv[7]  = '{OP_REMU, 32'd100,       32'd7,         32'h0000_0002, 1'b0, 8'd33};
        tv[8]  = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 8'd33};
        tv[9]  = '{OP_REM,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 8'd33};
        tv[10] = '{OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0, 8'd1};
        tv[11] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 8'd33};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) run_m_table($sformatf("div%0d", i), tv[i]);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        issue(OP_SUM, 32'd3, 32'd4);
        for (int i = 0; i < 10; i++) begin
            drive(OP_XOR, 32'd1, 32'd2);
            step();
            n_cmp++; if (bus.out_s !== 32'd7) begin n_err++; $display("FAIL bp_hold%0d_s got %h want 7", i, bus.out_s); end
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d_valid got %0b want 1", i, bus.out_valid); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d_in_ready got %0b want 0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        drive(OP_AND, 32'hFF, 32'h0F);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %0b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_release_valid got %0b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_s !== 32'h0F) begin n_err++; $display("FAIL bp_release_s got %h want 0000000f", bus.out_s); end
        step();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        drive(OP_SUM, 32'd10, 32'd20);
        step();
        n_cmp++; if (bus.out_s !== 32'd30) begin n_err++; $display("FAIL b2b0_s got %h want 1e", bus.out_s); end
        drive(OP_SUB, 32'd10, 32'd20);
        step();
        n_cmp++; if (bus.out_s !== 32'hFFFF_FFF6) begin n_err++; $display("FAIL b2b1_s got %h want fffffff6", bus.out_s); end
        drive(OP_SLL, 32'd1, 32'd31);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_s !== 32'h8000_0000) begin n_err++; $display("FAIL b2b2_s got %h want 80000000", bus.out_s); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b2_valid got %0b want 1", bus.out_valid); end
        step();
    endtask

    task automatic test_flush();
        logic seen;
        bus.out_ready = 1'b1;
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (8) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %0b want 0", bus.busy); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got %0b want 1", bus.in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_late_valid got %0b want 0", seen); end

        bus.out_ready = 1'b0;
        issue(OP_SUM, 32'd1, 32'd1);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        drive(OP_SUM, 32'd2, 32'd2);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_done_valid got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_done_busy got %0b want 0", bus.busy); end
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        issue(OP_SUM, 32'd1, 32'd1);
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) step();
        rst = 1'b1;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_s !== 32'h0) begin n_err++; $display("FAIL rstmid_s got %h want 0", bus.out_s); end
        n_cmp++; if (bus.out_zr !== 1'b0) begin n_err++; $display("FAIL rstmid_zr got %0b want 0", bus.out_zr); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %0b want 0", bus.busy); end
        rst = 1'b0;
        step();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got %0b want 1", bus.in_ready); end
        issue(OP_SUM, 32'd2, 32'd3);
        n_cmp++; if (bus.out_s !== 32'd5) begin n_err++; $display("FAIL rstmid_after_s got %h want 5", bus.out_s); end
        step();
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.operation = 5'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_base();
        test_mul();
        test_div();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
